// File: rtl/ifu_pkg.sv
// Shared types for the instruction-fetch stage: queue entry, FSM states
// and the PC step helper.
package ifu_pkg;

  localparam int INST_BYTES = 4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Sequential PC; wraps at 32 bits so 0xFFFF_FFFC steps to 0.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'(INST_BYTES);
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundle of the fetch stage's redirect, instruction-memory and decode-side
// signals; master is the fetch stage, slave is its environment.
interface ifu_fetch_if;
  import ifu_pkg::*;

  // Every channel is valid/ready: a transfer happens on a rising edge where
  // both are high, and payload is stable whenever valid is high. The
  // response channel has no ready; the fetch stage accepts every response.
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_req_addr;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;
  logic         fetch_valid;
  logic         fetch_ready;
  logic [31:0]  fetch_pc;
  logic [31:0]  fetch_inst;
  logic [31:0]  fetch_pc4;
  fetch_state_e state;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, fetch_ready,
    output imem_req_valid, imem_req_addr, fetch_valid, fetch_pc, fetch_inst,
           fetch_pc4, state
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, fetch_ready,
    input  imem_req_valid, imem_req_addr, fetch_valid, fetch_pc, fetch_inst,
           fetch_pc4, state
  );

endinterface

// File: rtl/ifu_fetch_queue.sv
// Small synchronous FIFO of fetch entries with flush; DEPTH is a power of two
// so the pointers wrap naturally.
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q;
  logic [AW-1:0]  wr_ptr_q;
  logic [CW-1:0]  count_q;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: head is only consumed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  // The credit rule upstream must keep a push from ever hitting a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests under a
// credit limit, queues responses for decode and drops stale ones on redirect.
// Optional IFU_PERF_EN adds perf_fetched / perf_stall counters.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_fetch_if.master bus
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int CW = $clog2(FQ_DEPTH+1);

  fetch_state_e   state_q, state_d;
  logic [31:0]    req_pc_q;
  logic [31:0]    rsp_pc_q;
  logic [CW-1:0]  outst_q, outst_d;
  logic [CW-1:0]  drop_q;
  logic [CW-1:0]  q_count;
  logic           q_full, q_empty;
  fetch_entry_t   q_head;
  fetch_entry_t   q_push_data;
  logic           req_valid;
  logic           credit_ok;
  logic           req_fire;
  logic           rsp_keep;
  logic           deq_fire;
  logic [31:0]    redirect_aligned;

  // Outstanding requests plus queued entries never exceed the queue depth,
  // so every response that comes back has a free slot waiting for it.
  assign credit_ok = ({1'b0, outst_q} + {1'b0, q_count}) < (CW+1)'(FQ_DEPTH);
  assign redirect_aligned = bus.redirect_pc & ~32'h3;

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        state_d   = RUN;
        req_valid = !bus.redirect_valid && credit_ok;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  assign req_fire = req_valid && bus.imem_req_ready;
  assign rsp_keep = bus.imem_rsp_valid && (drop_q == '0) && !bus.redirect_valid;
  assign deq_fire = !q_empty && bus.fetch_ready;

  always_comb begin
    outst_d = outst_q;
    case ({req_fire, bus.imem_rsp_valid})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
  end

  // On redirect every response still owed after this cycle is stale; no
  // request can fire in a redirect cycle, so that is exactly outst_d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
    end else begin
      outst_q <= outst_d;
      if (bus.redirect_valid) begin
        req_pc_q <= redirect_aligned;
        rsp_pc_q <= redirect_aligned;
        drop_q   <= outst_d;
      end else begin
        if (req_fire) req_pc_q <= next_pc(req_pc_q);
        if (bus.imem_rsp_valid) begin
          if (drop_q != '0) drop_q   <= drop_q - CW'(1);
          else              rsp_pc_q <= next_pc(rsp_pc_q);
        end
      end
    end
  end

  assign q_push_data = '{pc: rsp_pc_q, inst: bus.imem_rsp_data};

  ifu_fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect_valid),
    .push      (rsp_keep),
    .push_data (q_push_data),
    .pop       (deq_fire),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_pc_q;
  assign bus.fetch_valid    = !q_empty;
  assign bus.fetch_pc       = q_empty ? 32'h0 : q_head.pc;
  assign bus.fetch_inst     = q_empty ? 32'h0 : q_head.inst;
  assign bus.fetch_pc4      = q_empty ? 32'h0 : next_pc(q_head.pc);
  assign bus.state          = state_q;

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (deq_fire) perf_fetched <= perf_fetched + 32'd1;
      if (state_q == RUN && !req_valid && !bus.redirect_valid)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

  // Full is implied by the credit count; kept on the queue for its assertion.
  logic unused_full;
  assign unused_full = q_full;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomised scoreboard bench for ifu_fetch: a driver models memory and the
// expected fetch stream by epoch; a monitor pops and compares decode output.
module tb_ifu_fetch;
  import ifu_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    longint      due;
  } pend_t;

  logic clk;
  logic rst_n;
  ifu_fetch_if bus ();
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  ifu_fetch #(
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IFU_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // scoreboard state
  logic [63:0] exp_q[$];
  pend_t       pend_q[$];
  int          total, passed;
  longint      cyc, last_due;
  int          epoch, outst_m;
  logic [31:0] model_pc;
  bit          boot;

  // stimulus knobs
  int          ready_pct, fready_pct, lat_min, lat_max, redir_pm;
  bit          force_redir, redir_on_rsp, combo_hit;
  logic [31:0] force_target;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic timeout_fail(input string name);
    total++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.fetch_ready    = 1'b0;
    #1;
    check("rst_req_valid",   32'(bus.imem_req_valid), 32'd0);
    check("rst_fetch_valid", 32'(bus.fetch_valid),    32'd0);
    check("rst_fetch_pc",    bus.fetch_pc,            32'd0);
    check("rst_fetch_inst",  bus.fetch_inst,          32'd0);
    check("rst_fetch_pc4",   bus.fetch_pc4,           32'd0);
    check("rst_state",       32'(bus.state),          32'(BOOT));
    pend_q.delete();
    exp_q.delete();
    outst_m  = 0;
    model_pc = RESET_PC;
    boot     = 1'b1;
    last_due = cyc;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // driver: one clock of stimulus plus the reference model update
  task automatic step();
    logic        rsp, redir, exp_rv;
    logic [31:0] target;
    pend_t       p;
    longint      due;
    @(negedge clk);
    cyc++;
    bus.imem_req_ready = ($urandom_range(99) < ready_pct);
    bus.fetch_ready    = ($urandom_range(99) < fready_pct);
    rsp = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(pend_q[0].addr) : $urandom();
    redir  = force_redir || ($urandom_range(999) < redir_pm);
    target = force_redir ? force_target :
             (($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15))
                                       : $urandom());
    if (redir_on_rsp && rsp && bus.fetch_valid) begin
      redir = 1'b1;
      target = force_target;
      bus.fetch_ready = 1'b1;
      combo_hit = 1'b1;
    end
    bus.redirect_valid = redir;
    bus.redirect_pc    = target;
    #2;
    exp_rv = !boot && !redir && (outst_m + exp_q.size() < 2);
    check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      check("req_addr", bus.imem_req_addr, model_pc);
      due = cyc + longint'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      p.addr = model_pc; p.epoch = epoch; p.due = due;
      pend_q.push_back(p);
      model_pc = model_pc + 32'd4;
      outst_m++;
    end
    #2;
    if (rsp) begin
      p = pend_q.pop_front();
      outst_m--;
      if (!redir && p.epoch == epoch) exp_q.push_back({p.addr, mem_word(p.addr)});
    end
    if (redir) begin
      epoch++;
      exp_q.delete();
      model_pc = target & ~32'h3;
    end
    boot = 1'b0;
  endtask

  // monitor: compares whatever decode sees against the expected queue
  logic [63:0] mon_e;
  always begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      check("fetch_valid", 32'(bus.fetch_valid), 32'(exp_q.size() != 0));
      if (bus.fetch_valid && bus.fetch_ready && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("fetch_pc",   bus.fetch_pc,   mon_e[63:32]);
        check("fetch_inst", bus.fetch_inst, mon_e[31:0]);
        check("fetch_pc4",  bus.fetch_pc4,  mon_e[63:32] + 32'd4);
      end
    end
  end

  task automatic wait_outst2(input string name);
    for (int i = 0; i < 50 && outst_m != 2; i++) step();
    if (outst_m != 2) timeout_fail(name);
  endtask

  initial begin
    rst_n = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = '0;    bus.fetch_ready = 1'b0;
    total = 0; passed = 0; cyc = 0; last_due = 0; epoch = 0; outst_m = 0;
    model_pc = RESET_PC; boot = 1'b1;
    ready_pct = 100; fready_pct = 100; lat_min = 1; lat_max = 1; redir_pm = 0;
    force_redir = 1'b0; redir_on_rsp = 1'b0; combo_hit = 1'b0;
    force_target = '0;

    // straight-line fetch, 1-cycle memory
    do_reset();
    repeat (12) step();

    // decode backpressure fills the queue, then drains in order
    fready_pct = 0;   repeat (10) step();
    fready_pct = 100; repeat (10) step();

    // redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    wait_outst2("wait_outst_redirect");
    force_redir = 1'b1; force_target = 32'h8000_0100; step();
    force_redir = 1'b0;
    lat_min = 1; lat_max = 1;
    repeat (10) step();

    // redirect coinciding with a response and a dequeue
    lat_min = 1; lat_max = 2; force_target = 32'h8000_0200;
    redir_on_rsp = 1'b1;
    for (int i = 0; i < 200 && !combo_hit; i++) step();
    redir_on_rsp = 1'b0;
    if (!combo_hit) timeout_fail("combo_redirect");
    repeat (8) step();

    // misaligned redirect at the top of the address space
    lat_min = 1; lat_max = 1;
    force_redir = 1'b1; force_target = 32'hFFFF_FFFE; step();
    force_redir = 1'b0;
    repeat (8) step();

    // random traffic
    ready_pct = 70; fready_pct = 60; lat_min = 1; lat_max = 4; redir_pm = 30;
    repeat (3000) step();

    // asynchronous reset with two requests outstanding
    redir_pm = 0; ready_pct = 100; fready_pct = 100; lat_min = 3; lat_max = 3;
    wait_outst2("wait_outst_reset");
    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (10) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
